// File: rtl/addrdecode_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : addrdecode_pipe                                                 |
// | Desc   : Registered priority address decoder with optional skid buffer,  |
// |          saturating no-slave error counter and last-bad-address capture. |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module addrdecode_pipe #(
  parameter int                NS             = 4,
  parameter int                AW             = 32,
  parameter int                DW             = 32,
  parameter logic [NS*AW-1:0]  SLAVE_ADDR     = {32'h3000_0000, 32'h2000_0000,
                                                 32'h1000_0000, 32'h0000_0000},
  parameter logic [NS*AW-1:0]  SLAVE_MASK     = {NS{32'hF000_0000}},
  parameter logic [NS-1:0]     ACCESS_ALLOWED = {NS{1'b1}},
  parameter bit                OPT_SKIDBUFFER = 1'b1,
  parameter bit                OPT_LOWPOWER   = 1'b0,
  parameter int                CW             = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  output logic          o_stall,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_stall,
  output logic [NS:0]   o_decode,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data,
  input  logic          i_clr_err,
  output logic [CW-1:0] o_err_count,
  output logic [AW-1:0] o_err_addr
);

  localparam logic [CW-1:0] c_err_max = {CW{1'b1}};

  logic          r_valid;
  logic [NS:0]   r_decode;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic [CW-1:0] r_err_count;
  logic [AW-1:0] r_err_addr;

  logic          w_skid_valid;
  logic [AW-1:0] w_skid_addr;
  logic [DW-1:0] w_skid_data;
  logic          w_stall;
  logic          w_load;
  logic          w_accept;
  logic          w_src_valid;
  logic [AW-1:0] w_src_addr;
  logic [DW-1:0] w_src_data;
  logic [NS-1:0] w_match;
  logic [NS:0]   w_decode;
  logic          w_err_event;

  assign w_load      = !r_valid || !i_stall;
  assign w_accept    = i_valid && !w_stall;
  assign w_src_valid = w_skid_valid || i_valid;
  assign w_src_addr  = w_skid_valid ? w_skid_addr : i_addr;
  assign w_src_data  = w_skid_valid ? w_skid_data : i_data;

  generate
    for (genvar k = 0; k < NS; k++) begin : g_match
      assign w_match[k] = (((w_src_addr ^ SLAVE_ADDR[k*AW +: AW])
                            & SLAVE_MASK[k*AW +: AW]) == '0) && ACCESS_ALLOWED[k];
    end
  endgenerate

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    w_decode     = '0;
    w_decode[NS] = 1'b1;
    for (int k = NS - 1; k >= 0; k--) begin
      if (w_match[k]) begin
        w_decode    = '0;
        w_decode[k] = 1'b1;
      end
    end
  end

  generate
    if (OPT_SKIDBUFFER) begin : g_skid
      logic          r_skid_valid;
      logic [AW-1:0] r_skid_addr;
      logic [DW-1:0] r_skid_data;

      // Skid only fills while the output is held, and o_stall keeps it from refilling.
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
          r_skid_valid <= 1'b0;
          r_skid_addr  <= '0;
          r_skid_data  <= '0;
        end else if (w_load) begin
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_skid_valid <= 1'b1;
          r_skid_addr  <= i_addr;
          r_skid_data  <= i_data;
        end
      end

      assign w_skid_valid = r_skid_valid;
      assign w_skid_addr  = r_skid_addr;
      assign w_skid_data  = r_skid_data;
      assign w_stall      = r_skid_valid;
    end else begin : g_noskid
      assign w_skid_valid = 1'b0;
      assign w_skid_addr  = '0;
      assign w_skid_data  = '0;
      assign w_stall      = r_valid && i_stall;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid  <= 1'b0;
      r_decode <= '0;
      r_addr   <= '0;
      r_data   <= '0;
    end else if (w_load) begin
      r_valid <= w_src_valid;
      if (w_src_valid) begin
        r_decode <= w_decode;
        r_addr   <= w_src_addr;
        r_data   <= w_src_data;
      end else begin
        r_decode <= '0;
        if (OPT_LOWPOWER) begin
          r_addr <= '0;
          r_data <= '0;
        end
      end
    end
  end

  assign w_err_event = r_valid && !i_stall && r_decode[NS];

  // A clear coinciding with an error event counts that event.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else begin
      if (w_err_event)
        r_err_addr <= r_addr;
      if (i_clr_err)
        r_err_count <= w_err_event ? CW'(1) : '0;
      else if (w_err_event && (r_err_count != c_err_max))
        r_err_count <= r_err_count + 1'b1;
    end
  end

  assign o_stall     = w_stall;
  assign o_valid     = r_valid;
  assign o_decode    = r_decode;
  assign o_addr      = r_addr;
  assign o_data      = r_data;
  assign o_err_count = r_err_count;
  assign o_err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_addrdecode_pipe.sv
`default_nettype none
// Testbench for addrdecode_pipe: default instance checked each cycle against a
// queue-level model, plus directed literal checks across alternate configurations.
module tb_addrdecode_pipe;

  logic        clk = 1'b0;
  logic        in_reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic        in_stall = 1'b0;
  logic        in_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // d0: default, d1: slave 1 matches all, d2: d1 with slave 1 disallowed,
  // d3: 2-bit error counter, d4: no skid buffer with low-power outputs.
  logic        d0_stall, d0_valid, d1_stall, d1_valid, d2_stall, d2_valid;
  logic        d3_stall, d3_valid, d4_stall, d4_valid;
  logic [4:0]  d0_dec, d1_dec, d2_dec, d3_dec, d4_dec;
  logic [31:0] d0_addr, d1_addr, d2_addr, d3_addr, d4_addr;
  logic [31:0] d0_data, d1_data, d2_data, d3_data, d4_data;
  logic [15:0] d0_ecnt, d1_ecnt, d2_ecnt, d4_ecnt;
  logic [1:0]  d3_ecnt;
  logic [31:0] d0_eaddr, d1_eaddr, d2_eaddr, d3_eaddr, d4_eaddr;

  addrdecode_pipe u_d0 (
    .i_clk(clk), .i_reset(in_reset), .i_valid(in_valid), .o_stall(d0_stall),
    .i_addr(in_addr), .i_data(in_data), .o_valid(d0_valid), .i_stall(in_stall),
    .o_decode(d0_dec), .o_addr(d0_addr), .o_data(d0_data), .i_clr_err(in_clr),
    .o_err_count(d0_ecnt), .o_err_addr(d0_eaddr));

  addrdecode_pipe #(
    .SLAVE_MASK({32'hF000_0000, 32'hF000_0000, 32'h0000_0000, 32'hF000_0000})
  ) u_d1 (
    .i_clk(clk), .i_reset(in_reset), .i_valid(in_valid), .o_stall(d1_stall),
    .i_addr(in_addr), .i_data(in_data), .o_valid(d1_valid), .i_stall(in_stall),
    .o_decode(d1_dec), .o_addr(d1_addr), .o_data(d1_data), .i_clr_err(in_clr),
    .o_err_count(d1_ecnt), .o_err_addr(d1_eaddr));

  addrdecode_pipe #(
    .SLAVE_MASK({32'hF000_0000, 32'hF000_0000, 32'h0000_0000, 32'hF000_0000}),
    .ACCESS_ALLOWED(4'b1101)
  ) u_d2 (
    .i_clk(clk), .i_reset(in_reset), .i_valid(in_valid), .o_stall(d2_stall),
    .i_addr(in_addr), .i_data(in_data), .o_valid(d2_valid), .i_stall(in_stall),
    .o_decode(d2_dec), .o_addr(d2_addr), .o_data(d2_data), .i_clr_err(in_clr),
    .o_err_count(d2_ecnt), .o_err_addr(d2_eaddr));

  addrdecode_pipe #(.CW(2)) u_d3 (
    .i_clk(clk), .i_reset(in_reset), .i_valid(in_valid), .o_stall(d3_stall),
    .i_addr(in_addr), .i_data(in_data), .o_valid(d3_valid), .i_stall(in_stall),
    .o_decode(d3_dec), .o_addr(d3_addr), .o_data(d3_data), .i_clr_err(in_clr),
    .o_err_count(d3_ecnt), .o_err_addr(d3_eaddr));

  addrdecode_pipe #(.OPT_SKIDBUFFER(1'b0), .OPT_LOWPOWER(1'b1)) u_d4 (
    .i_clk(clk), .i_reset(in_reset), .i_valid(in_valid), .o_stall(d4_stall),
    .i_addr(in_addr), .i_data(in_data), .o_valid(d4_valid), .i_stall(in_stall),
    .o_decode(d4_dec), .o_addr(d4_addr), .o_data(d4_data), .i_clr_err(in_clr),
    .o_err_count(d4_ecnt), .o_err_addr(d4_eaddr));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Default windows: top nibble 0..3 selects that slave, anything else is unmapped.
  function automatic logic [4:0] ref_decode(input logic [31:0] a);
    logic [4:0] d;
    d = '0;
    if (a[31:28] < 4'd4) d[a[31:28]] = 1'b1;
    else                 d[4] = 1'b1;
    return d;
  endfunction

  // Pipeline viewed as an ordered queue of at most two beats (output + skid).
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       mq[$];
  int          mdl_cnt = 0;
  logic [31:0] mdl_eaddr = '0;

  always @(posedge clk or posedge in_reset) begin
    if (in_reset) begin
      mq.delete();
      mdl_cnt   = 0;
      mdl_eaddr = '0;
    end else begin
      bit full_before;
      bit ev;
      beat_t b;
      full_before = (mq.size() == 2);
      ev = 1'b0;
      if (mq.size() > 0 && !in_stall) begin
        if (ref_decode(mq[0].addr) == 5'b10000) begin
          ev = 1'b1;
          mdl_eaddr = mq[0].addr;
        end
        void'(mq.pop_front());
      end
      if (in_clr)                     mdl_cnt = ev ? 1 : 0;
      else if (ev && mdl_cnt < 65535) mdl_cnt = mdl_cnt + 1;
      if (in_valid && !full_before) begin
        b.addr = in_addr;
        b.data = in_data;
        mq.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    check("mdl_valid", d0_valid, mq.size() != 0);
    check("mdl_stall", d0_stall, mq.size() == 2);
    check("mdl_decode", d0_dec, (mq.size() != 0) ? ref_decode(mq[0].addr) : 5'b0);
    if (mq.size() != 0) begin
      check("mdl_addr", d0_addr, mq[0].addr);
      check("mdl_data", d0_data, mq[0].data);
    end
    check("mdl_err_count", d0_ecnt, mdl_cnt);
    check("mdl_err_addr", d0_eaddr, mdl_eaddr);
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic s);
    in_valid = v;
    in_addr  = a;
    in_data  = a ^ 32'hA5A5_A5A5;
    in_stall = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] b2b_addr [3];
  logic [4:0]  b2b_dec  [3];

  initial begin
    b2b_addr[0] = 32'h0000_0010; b2b_dec[0] = 5'b00001;
    b2b_addr[1] = 32'h1000_0020; b2b_dec[1] = 5'b00010;
    b2b_addr[2] = 32'h3FFF_FFFC; b2b_dec[2] = 5'b01000;

    #1 in_reset = 1'b1;
    repeat (2) step();
    check("rst_valid", d0_valid, 1'b0);
    check("rst_stall", d0_stall, 1'b0);
    check("rst_decode", d0_dec, 5'b0);
    check("rst_err_count", d0_ecnt, 16'd0);
    check("rst_err_addr", d0_eaddr, 32'd0);
    check("rst_addr", d0_addr, 32'd0);
    check("rst_data", d0_data, 32'd0);
    in_reset = 1'b0;
    step();

    // Back-to-back beats, one cycle latency each
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, b2b_addr[i], 1'b0);
      step();
      check("b2b_decode", d0_dec, b2b_dec[i]);
      check("b2b_stall", d0_stall, 1'b0);
    end
    // Overlapping windows and access permission
    drive(1'b1, 32'h2000_0000, 1'b0);
    step();
    check("ovl_default", d0_dec, 5'b00100);
    check("ovl_lowest_wins", d1_dec, 5'b00010);
    check("ovl_disallowed", d2_dec, 5'b00100);
    drive(1'b0, 32'h0, 1'b0);
    step();
    check("idle_valid", d0_valid, 1'b0);
    check("idle_decode", d0_dec, 5'b0);
    check("lowpower_addr", d4_addr, 32'd0);
    check("lowpower_data", d4_data, 32'd0);
    check("lowpower_decode", d4_dec, 5'b0);

    // Unmapped handoffs and clear coinciding with an error
    drive(1'b1, 32'h8000_0004, 1'b0);
    step();
    check("unmapped_decode", d0_dec, 5'b10000);
    step();
    check("err_count_1", d0_ecnt, 16'd1);
    check("err_addr", d0_eaddr, 32'h8000_0004);
    step();
    check("err_count_2", d0_ecnt, 16'd2);
    drive(1'b0, 32'h0, 1'b0);
    in_clr = 1'b1;
    step();
    check("err_clr_with_event", d0_ecnt, 16'd1);
    check("err_clr_with_event_cw2", d3_ecnt, 2'd1);
    check("err_addr_kept", d0_eaddr, 32'h8000_0004);
    step();
    in_clr = 1'b0;
    check("err_clr_alone", d0_ecnt, 16'd0);
    check("err_clr_alone_cw2", d3_ecnt, 2'd0);

    // Saturation with a 2-bit counter
    for (int k = 0; k <= 5; k++) begin
      drive(k < 5, 32'h9000_0008, 1'b0);
      step();
      if (k >= 1) begin
        check("sat_cw2", d3_ecnt, (k > 3) ? 2'd3 : 2'(k));
        check("sat_cw16", d0_ecnt, 16'(k));
      end
    end

    // Downstream stall across a stream A, B, C
    drive(1'b1, 32'h0000_0100, 1'b0);
    step();
    check("stall_A_out", d0_addr, 32'h0000_0100);
    check("stall_A_nostall", d0_stall, 1'b0);
    drive(1'b1, 32'h1000_0200, 1'b1);
    #1 check("noskid_stall_rise", d4_stall, 1'b1);
    step();
    check("stall_hold_A_1", d0_addr, 32'h0000_0100);
    check("stall_skid_full", d0_stall, 1'b1);
    drive(1'b1, 32'h2000_0300, 1'b1);
    step();
    check("stall_hold_A_2", d0_addr, 32'h0000_0100);
    step();
    check("stall_hold_A_3", d0_addr, 32'h0000_0100);
    check("stall_still_full", d0_stall, 1'b1);
    in_stall = 1'b0;
    #1 check("noskid_stall_fall", d4_stall, 1'b0);
    step();
    check("release_B_out", d0_addr, 32'h1000_0200);
    check("release_stall_drop", d0_stall, 1'b0);
    step();
    check("release_C_out", d0_addr, 32'h2000_0300);
    check("release_C_dec", d0_dec, 5'b00100);
    drive(1'b0, 32'h0, 1'b0);
    step();
    check("release_drain", d0_valid, 1'b0);

    // Asynchronous reset with output valid and skid full
    drive(1'b1, 32'h0000_0400, 1'b0);
    step();
    drive(1'b1, 32'h1000_0500, 1'b1);
    step();
    check("pre_rst_stall", d0_stall, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #2 in_reset = 1'b1;
    #1;
    check("async_rst_valid", d0_valid, 1'b0);
    check("async_rst_stall", d0_stall, 1'b0);
    check("async_rst_decode", d0_dec, 5'b0);
    check("async_rst_err_count", d0_ecnt, 16'd0);
    check("async_rst_noskid_stall", d4_stall, 1'b0);
    step();
    in_reset = 1'b0;
    drive(1'b1, 32'h1000_0000, 1'b0);
    step();
    check("post_rst_valid", d0_valid, 1'b1);
    check("post_rst_decode", d0_dec, 5'b00010);
    drive(1'b0, 32'h0, 1'b0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
